// File: rtl/touch_pkg.sv
// touch_pkg: shared types for the touch event filter.
//   evt_t        - event kind carried through the event FIFO
//   touch_evt_s  - one FIFO entry: event kind plus X/Y position
//   fsm_state_t  - filter FSM state, also exported on the debug port
//   abs_diff     - unsigned distance between two 12-bit coordinates
package touch_pkg;

   typedef enum logic [1:0] {
      EVT_NONE    = 2'd0,
      EVT_PRESS   = 2'd1,
      EVT_MOVE    = 2'd2,
      EVT_RELEASE = 2'd3
   } evt_t;

   typedef struct packed {
      evt_t        etype;
      logic [11:0] x;
      logic [11:0] y;
   } touch_evt_s;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_DOWN = 2'd2,
      ST_REL  = 2'd3
   } fsm_state_t;

   function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/touch_event_filter_if.sv
// touch_event_filter_if: event stream from the filter to the processor.
//   evt_valid  head of the event FIFO holds an event (also a level IRQ)
//   evt_ready  consumer takes the head when evt_valid & evt_ready
//   evt_type   kind of the head event
//   evt_x/y    position of the head event
// Handshake: a transfer happens on every rising clk edge where evt_valid and
// evt_ready are both 1; while evt_valid=1 and evt_ready=0 the payload holds
// steady; evt_ready is ignored while evt_valid=0.
// Modports: master = event source (filter), slave = consumer.
interface touch_event_filter_if;
   import touch_pkg::*;

   logic        evt_valid;
   logic        evt_ready;
   evt_t        evt_type;
   logic [11:0] evt_x;
   logic [11:0] evt_y;

   modport master (output evt_valid, output evt_type, output evt_x, output evt_y,
                   input  evt_ready);
   modport slave  (input  evt_valid, input  evt_type, input  evt_x, input  evt_y,
                   output evt_ready);
endinterface

// File: rtl/touch_event_fifo.sv
// touch_event_fifo: first-word-fall-through FIFO of touch_evt_s entries.
//   clk, rst    clock, asynchronous active-high reset (empties the FIFO)
//   push        write push_data this clk (dropped if full and not popping)
//   push_data   entry to write
//   full        all DEPTH entries occupied
//   pop         consumer accepts head (ignored while empty)
//   valid       head holds an entry
//   head        current head entry, all-zero while empty
//   dropped     1 during a clk where a push is lost because the FIFO is full
// Pointers carry one extra MSB so full and empty are distinguishable.
module touch_event_fifo
   import touch_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  touch_evt_s push_data,
   output logic       full,
   input  logic       pop,
   output logic       valid,
   output touch_evt_s head,
   output logic       dropped
);

   localparam int AW = $clog2(DEPTH);

   touch_evt_s    mem [DEPTH];
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic          pop_fire;
   logic          push_fire;

   assign valid     = (wptr != rptr);
   assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop_fire  = pop && valid;
   // A pop in the same clk frees the slot, so a push into a full FIFO still lands.
   assign push_fire = push && (!full || pop_fire);
   assign dropped   = push && full && !pop_fire;
   assign head      = valid ? mem[rptr[AW-1:0]] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_fire) wptr <= wptr + 1'b1;
         if (pop_fire)  rptr <= rptr + 1'b1;
      end
   end

   // Storage needs no reset: head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (push_fire) mem[wptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/touch_event_filter.sv
// touch_event_filter: debounces/averages digitizer samples into PRESS,
// RELEASE and (optionally) MOVE events, buffered in a FIFO for the processor.
//   clk, rst      processor clock, asynchronous active-high reset
//   sample_stb    1-clk pulse: touching/x_coord/y_coord valid
//   touching      raw pen-down flag
//   x_coord/y     raw 12-bit sample
//   evt           event stream (touch_event_filter_if.master)
//   down          filtered pen-down state
//   cur_x/cur_y   last averaged position
//   overflow      sticky: an event was dropped because the FIFO was full
//   ovf_clr       1-clk pulse clearing overflow (a same-clk drop wins)
//   state         FSM state, for debug visibility
// Optional feature: define TOUCH_FILTER_MOVE_EN to emit MOVE events when the
// averaged position moves by at least MOVE_THRESH on either axis from the
// last emitted PRESS/MOVE position.
// Assumes AVG_LOG2 >= 1 and RELEASE_CNT >= 2.
module touch_event_filter
   import touch_pkg::*;
#(
   parameter int AVG_LOG2    = 2,
   parameter int RELEASE_CNT = 3,
   parameter int FIFO_DEPTH  = 8,
   parameter int MOVE_THRESH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_stb,
   input  logic                 touching,
   input  logic [11:0]          x_coord,
   input  logic [11:0]          y_coord,
   touch_event_filter_if.master evt,
   output logic                 down,
   output logic [11:0]          cur_x,
   output logic [11:0]          cur_y,
   output logic                 overflow,
   input  logic                 ovf_clr,
   output fsm_state_t           state
);

`ifdef TOUCH_FILTER_MOVE_EN
   localparam bit MOVE_EN = 1'b1;
`else
   localparam bit MOVE_EN = 1'b0;
`endif

   localparam int SW = 12 + AVG_LOG2;
   localparam int RW = $clog2(RELEASE_CNT + 1);

   logic [SW-1:0]       sum_x, sum_y;
   logic [SW-1:0]       sum_nx, sum_ny;
   logic [SW-1:0]       smp_x, smp_y;
   logic [11:0]         avg_x, avg_y;
   logic [AVG_LOG2-1:0] win_cnt;
   logic                win_full;
   logic [RW-1:0]       rel_cnt;
   logic [11:0]         ref_x, ref_y;
   logic                move_hit;
   logic                push_req;
   touch_evt_s          push_data;
   touch_evt_s          head;
   logic                fifo_full;
   logic                fifo_valid;
   logic                fifo_dropped;

   assign smp_x    = {{AVG_LOG2{1'b0}}, x_coord};
   assign smp_y    = {{AVG_LOG2{1'b0}}, y_coord};
   assign sum_nx   = sum_x + smp_x;
   assign sum_ny   = sum_y + smp_y;
   // Window average including the current sample; truncating shift.
   assign avg_x    = sum_nx[SW-1:AVG_LOG2];
   assign avg_y    = sum_ny[SW-1:AVG_LOG2];
   // win_cnt holds samples already summed; all-ones means this one completes it.
   assign win_full = &win_cnt;
   assign move_hit = (abs_diff(avg_x, ref_x) >= 12'(MOVE_THRESH)) ||
                     (abs_diff(avg_y, ref_y) >= 12'(MOVE_THRESH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         sum_x     <= '0;
         sum_y     <= '0;
         win_cnt   <= '0;
         rel_cnt   <= '0;
         cur_x     <= '0;
         cur_y     <= '0;
         ref_x     <= '0;
         ref_y     <= '0;
         down      <= 1'b0;
         push_req  <= 1'b0;
         push_data <= '0;
         overflow  <= 1'b0;
      end else begin
         push_req <= 1'b0;

         if (fifo_dropped)  overflow <= 1'b1;
         else if (ovf_clr)  overflow <= 1'b0;

         if (sample_stb) begin
            case (state)
               ST_IDLE: begin
                  if (touching) begin
                     sum_x   <= smp_x;
                     sum_y   <= smp_y;
                     win_cnt <= AVG_LOG2'(1);
                     state   <= ST_PEND;
                  end
               end

               ST_PEND: begin
                  if (touching) begin
                     if (win_full) begin
                        cur_x     <= avg_x;
                        cur_y     <= avg_y;
                        ref_x     <= avg_x;
                        ref_y     <= avg_y;
                        push_req  <= 1'b1;
                        push_data <= '{etype: EVT_PRESS, x: avg_x, y: avg_y};
                        down      <= 1'b1;
                        sum_x     <= '0;
                        sum_y     <= '0;
                        win_cnt   <= '0;
                        state     <= ST_DOWN;
                     end else begin
                        sum_x   <= sum_nx;
                        sum_y   <= sum_ny;
                        win_cnt <= win_cnt + 1'b1;
                     end
                  end else begin
                     sum_x   <= '0;
                     sum_y   <= '0;
                     win_cnt <= '0;
                     state   <= ST_IDLE;
                  end
               end

               ST_DOWN: begin
                  if (touching) begin
                     if (win_full) begin
                        cur_x   <= avg_x;
                        cur_y   <= avg_y;
                        sum_x   <= '0;
                        sum_y   <= '0;
                        win_cnt <= '0;
                        if (MOVE_EN && move_hit) begin
                           ref_x     <= avg_x;
                           ref_y     <= avg_y;
                           push_req  <= 1'b1;
                           push_data <= '{etype: EVT_MOVE, x: avg_x, y: avg_y};
                        end
                     end else begin
                        sum_x   <= sum_nx;
                        sum_y   <= sum_ny;
                        win_cnt <= win_cnt + 1'b1;
                     end
                  end else begin
                     sum_x   <= '0;
                     sum_y   <= '0;
                     win_cnt <= '0;
                     rel_cnt <= RW'(1);
                     state   <= ST_REL;
                  end
               end

               ST_REL: begin
                  if (!touching) begin
                     if (rel_cnt == RW'(RELEASE_CNT - 1)) begin
                        push_req  <= 1'b1;
                        push_data <= '{etype: EVT_RELEASE, x: cur_x, y: cur_y};
                        down      <= 1'b0;
                        rel_cnt   <= '0;
                        state     <= ST_IDLE;
                     end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                     end
                  end else begin
                     // Pen came back: resume tracking, this sample opens a new window.
                     rel_cnt <= '0;
                     sum_x   <= smp_x;
                     sum_y   <= smp_y;
                     win_cnt <= AVG_LOG2'(1);
                     state   <= ST_DOWN;
                  end
               end

               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   touch_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_req),
      .push_data (push_data),
      .full      (fifo_full),
      .pop       (evt.evt_ready),
      .valid     (fifo_valid),
      .head      (head),
      .dropped   (fifo_dropped)
   );

   assign evt.evt_valid = fifo_valid;
   assign evt.evt_type  = head.etype;
   assign evt.evt_x     = head.x;
   assign evt.evt_y     = head.y;

endmodule
